// File: rtl/alu_multiciclo.sv
// alu_multiciclo: multi-cycle ALU with a valid/ready handshake on both sides.
//   Most operations finish one cycle after acceptance. Multiply uses a
//   shift-and-add loop of LARGURA iterations.
// Ports:
//   clk        - clock; all state changes on its rising edge
//   reset      - asynchronous active-high reset
//   codop      - operation select, sampled when a command is accepted
//   operando1  - first operand, sampled when a command is accepted
//   operando2  - second operand, sampled when a command is accepted
//   valido_in  - the source presents a command
//   pronto_in  - the block can accept a command (only while idle)
//   resultado  - registered result
//   flags      - {erro, negativo, overflow, carry, zero} describing resultado
//   valido_out - resultado/flags are valid
//   pronto_out - the sink consumes the result this cycle
module alu_multiciclo #(
  parameter int LARGURA  = 16,
  parameter int LARG_COD = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LARG_COD-1:0] codop,
  input  logic [LARGURA-1:0]  operando1,
  input  logic [LARGURA-1:0]  operando2,
  input  logic                valido_in,
  output logic                pronto_in,
  output logic [LARGURA-1:0]  resultado,
  output logic [4:0]          flags,
  output logic                valido_out,
  input  logic                pronto_out
);

  localparam int CW = $clog2(LARGURA + 1);
  localparam logic [LARG_COD-1:0] OP_MUL = LARG_COD'(8);

  typedef enum logic [1:0] {OCIOSO, CALCULA, PRONTO} estado_t;
  estado_t estado;

  // Multiply state: the accumulator and multiplicand are double width so
  // that the truncated high half of the product is available for carry.
  logic [2*LARGURA-1:0] acc;
  logic [2*LARGURA-1:0] mcand;
  logic [LARGURA-1:0]   mplier;
  logic [CW-1:0]        cont;

  // Single-cycle datapath
  logic [LARGURA-1:0] amt;
  logic [LARGURA:0]   soma;
  logic [LARGURA:0]   dif;
  logic [LARGURA:0]   shl_w;
  logic [LARGURA:0]   shr_w;
  logic [LARGURA-1:0] alu_res;
  logic               alu_cy;
  logic               alu_ov;
  logic               alu_err;
  logic [4:0]         alu_flags;

  always_comb begin
    amt   = operando2 % LARGURA'(LARGURA);
    soma  = {1'b0, operando1} + {1'b0, operando2};
    dif   = {1'b0, operando1} - {1'b0, operando2};
    // One extra bit on the outgoing side catches the last bit shifted out;
    // a shift amount of 0 leaves that bit at 0.
    shl_w = {1'b0, operando1} << amt;
    shr_w = {operando1, 1'b0} >> amt;

    alu_res = '0;
    alu_cy  = 1'b0;
    alu_ov  = 1'b0;
    alu_err = 1'b0;
    case (codop)
      LARG_COD'(0): begin
        alu_res = soma[LARGURA-1:0];
        alu_cy  = soma[LARGURA];
        alu_ov  = (operando1[LARGURA-1] == operando2[LARGURA-1]) &&
                  (soma[LARGURA-1] != operando1[LARGURA-1]);
      end
      LARG_COD'(1): begin
        alu_res = dif[LARGURA-1:0];
        alu_cy  = ~dif[LARGURA];  // no borrow
        alu_ov  = (operando1[LARGURA-1] != operando2[LARGURA-1]) &&
                  (dif[LARGURA-1] != operando1[LARGURA-1]);
      end
      LARG_COD'(2): alu_res = {{(LARGURA-1){1'b0}}, operando1 > operando2};
      LARG_COD'(3): alu_res = operando1 & operando2;
      LARG_COD'(4): alu_res = operando1 | operando2;
      LARG_COD'(5): alu_res = operando1 ^ operando2;
      LARG_COD'(6): begin
        alu_res = shl_w[LARGURA-1:0];
        alu_cy  = shl_w[LARGURA];
      end
      LARG_COD'(7): begin
        alu_res = shr_w[LARGURA:1];
        alu_cy  = shr_w[0];
      end
      LARG_COD'(8): alu_res = '0;  // handled by the iterative path
      LARG_COD'(9): alu_res = {{(LARGURA-1){1'b0}},
                               $signed(operando1) > $signed(operando2)};
      default:      alu_err = 1'b1;
    endcase

    if (alu_err)
      alu_flags = 5'b10000;
    else
      alu_flags = {1'b0, alu_res[LARGURA-1], alu_ov, alu_cy, alu_res == '0};
  end

  // Shift-and-add step
  logic [2*LARGURA-1:0] acc_next;
  logic [LARGURA-1:0]   mul_res;
  logic [4:0]           mul_flags;

  always_comb begin
    acc_next  = acc + (mplier[0] ? mcand : '0);
    mul_res   = acc_next[LARGURA-1:0];
    mul_flags = {1'b0, mul_res[LARGURA-1], 1'b0,
                 |acc_next[2*LARGURA-1:LARGURA], mul_res == '0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado     <= OCIOSO;
      resultado  <= '0;
      flags      <= '0;
      valido_out <= 1'b0;
      pronto_in  <= 1'b1;
      cont       <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (valido_in) begin
            pronto_in <= 1'b0;
            if (codop == OP_MUL) begin
              estado <= CALCULA;
              acc    <= '0;
              mcand  <= {{LARGURA{1'b0}}, operando1};
              mplier <= operando2;
              cont   <= '0;
            end else begin
              estado     <= PRONTO;
              resultado  <= alu_res;
              flags      <= alu_flags;
              valido_out <= 1'b1;
            end
          end
        end
        CALCULA: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cont == CW'(LARGURA - 1)) begin
            cont       <= '0;
            estado     <= PRONTO;
            resultado  <= mul_res;
            flags      <= mul_flags;
            valido_out <= 1'b1;
          end else begin
            cont <= cont + CW'(1);
          end
        end
        PRONTO: begin
          // Result stays put until consumed; pronto_in only returns once
          // idle, which forces a gap cycle between commands.
          if (pronto_out) begin
            estado     <= OCIOSO;
            valido_out <= 1'b0;
            pronto_in  <= 1'b1;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Testbench for alu_multiciclo: directed vector table, random commands against
// an arithmetic reference model, and hand-written multi-cycle sequences.
module tb_alu_multiciclo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  codop = '0;
  logic [15:0] operando1 = '0;
  logic [15:0] operando2 = '0;
  logic        valido_in = 1'b0;
  logic        pronto_in;
  logic [15:0] resultado;
  logic [4:0]  flags;
  logic        valido_out;
  logic        pronto_out = 1'b0;

  logic [3:0]  c8 = '0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        vi8 = 1'b0;
  logic        pi8;
  logic [7:0]  r8;
  logic [4:0]  f8;
  logic        vo8;
  logic        po8 = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_multiciclo #(.LARGURA(16), .LARG_COD(4)) dut (
    .clk(clk), .reset(reset), .codop(codop), .operando1(operando1),
    .operando2(operando2), .valido_in(valido_in), .pronto_in(pronto_in),
    .resultado(resultado), .flags(flags), .valido_out(valido_out),
    .pronto_out(pronto_out)
  );

  alu_multiciclo #(.LARGURA(8), .LARG_COD(4)) dut8 (
    .clk(clk), .reset(reset), .codop(c8), .operando1(a8),
    .operando2(b8), .valido_in(vi8), .pronto_in(pi8),
    .resultado(r8), .flags(f8), .valido_out(vo8),
    .pronto_out(po8)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // Reference model computed from the operation definitions with wide integers.
  function automatic void model(input logic [3:0] c, input logic [15:0] a,
                                input logic [15:0] b, output logic [15:0] r,
                                output logic [4:0] f);
    longint ua, ub, full, sa, sb, sr;
    int s;
    bit cy, ov, er;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    cy = 0; ov = 0; er = 0; full = 0;
    case (c)
      4'd0: begin full = ua + ub; cy = full >= 65536; sr = sa + sb; ov = sr > 32767 || sr < -32768; end
      4'd1: begin full = ua - ub; cy = ua >= ub; sr = sa - sb; ov = sr > 32767 || sr < -32768; end
      4'd2: full = (ua > ub) ? 1 : 0;
      4'd3: full = ua & ub;
      4'd4: full = ua | ub;
      4'd5: full = ua ^ ub;
      4'd6: begin s = int'(ub % 16); full = ua << s; cy = (s != 0) && (((ua >> (16 - s)) & 1) != 0); end
      4'd7: begin s = int'(ub % 16); full = ua >> s; cy = (s != 0) && (((ua >> (s - 1)) & 1) != 0); end
      4'd8: begin full = ua * ub; cy = full >= 65536; end
      4'd9: full = (sa > sb) ? 1 : 0;
      default: er = 1;
    endcase
    r = full[15:0];
    f = er ? 5'b10000 : {1'b0, r[15], ov, cy, r == 16'h0};
  endfunction

  // One complete transaction; called with time at posedge+1.
  task automatic do_op(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r, output logic [4:0] f, output int lat);
    for (int i = 0; i < 50 && !pronto_in; i++) begin
      @(posedge clk); #1;
    end
    chk("ready_before_cmd", pronto_in, 1);
    codop = c; operando1 = a; operando2 = b; valido_in = 1'b1;
    @(posedge clk); #1;
    valido_in = 1'b0;
    lat = 1;
    while (!valido_out && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    r = resultado;
    f = flags;
    chk("busy_in_pronto", pronto_in, 0);
    pronto_out = 1'b1;
    @(posedge clk); #1;
    pronto_out = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  c;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [4:0]  f;
    int          lat;
  } vec_t;

  vec_t vt[16];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] r, r0, rm;
    logic [4:0]  f, f0, fm;
    int lat, seen;
    logic [3:0]  rc;
    logic [15:0] ra, rb;

    vt[0]  = '{4'd0, 16'hFFFF, 16'h0001, 16'h0000, 5'b00011, 1};
    vt[1]  = '{4'd1, 16'h8000, 16'h0001, 16'h7FFF, 5'b00110, 1};
    vt[2]  = '{4'd2, 16'h0005, 16'h0003, 16'h0001, 5'b00000, 1};
    vt[3]  = '{4'd9, 16'hFFFF, 16'h0001, 16'h0000, 5'b00001, 1};
    vt[4]  = '{4'd8, 16'h0100, 16'h0100, 16'h0000, 5'b00011, 17};
    vt[5]  = '{4'hF, 16'h1234, 16'h5678, 16'h0000, 5'b10000, 1};
    vt[6]  = '{4'hA, 16'h0001, 16'h0001, 16'h0000, 5'b10000, 1};
    vt[7]  = '{4'd6, 16'h8001, 16'h0001, 16'h0002, 5'b00010, 1};
    vt[8]  = '{4'd7, 16'h0003, 16'h0011, 16'h0001, 5'b00010, 1};
    vt[9]  = '{4'd6, 16'h1234, 16'h0010, 16'h1234, 5'b00000, 1};
    vt[10] = '{4'd3, 16'hF0F0, 16'hFF00, 16'hF000, 5'b01000, 1};
    vt[11] = '{4'd5, 16'hAAAA, 16'hAAAA, 16'h0000, 5'b00001, 1};
    vt[12] = '{4'd8, 16'h0003, 16'h0005, 16'h000F, 5'b00000, 17};
    vt[13] = '{4'd1, 16'h0003, 16'h0005, 16'hFFFE, 5'b01000, 1};
    vt[14] = '{4'd4, 16'h0001, 16'h8000, 16'h8001, 5'b01000, 1};
    vt[15] = '{4'd0, 16'h7FFF, 16'h0001, 16'h8000, 5'b01100, 1};

    // Reset state
    #2;
    chk("rst_resultado", resultado, 0);
    chk("rst_flags", flags, 0);
    chk("rst_valido_out", valido_out, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_pronto_in", pronto_in, 1);

    // Directed table
    foreach (vt[i]) begin
      do_op(vt[i].c, vt[i].a, vt[i].b, r, f, lat);
      chk($sformatf("vec%0d_res", i), r, vt[i].r);
      chk($sformatf("vec%0d_flags", i), f, vt[i].f);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
      $display("vec %0d: cod=%0d a=%h b=%h -> res=%h flags=%b lat=%0d", i, vt[i].c, vt[i].a, vt[i].b, r, f, lat);
    end

    // Random commands against the reference model
    for (int i = 0; i < 40; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = 16'($urandom);
      rb = (i % 4 == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      model(rc, ra, rb, rm, fm);
      do_op(rc, ra, rb, r, f, lat);
      chk($sformatf("rnd%0d_res", i), r, rm);
      chk($sformatf("rnd%0d_flags", i), f, fm);
      chk($sformatf("rnd%0d_lat", i), lat, (rc == 4'd8) ? 17 : 1);
      $display("rnd %0d: cod=%0d a=%h b=%h -> res=%h flags=%b lat=%0d", i, rc, ra, rb, r, f, lat);
    end

    // Backpressure: result held, new commands ignored, no same-cycle accept
    codop = 4'd0; operando1 = 16'd2; operando2 = 16'd3; valido_in = 1'b1;
    @(posedge clk); #1;
    r0 = resultado; f0 = flags;
    chk("bp_first_res", r0, 16'd5);
    for (int k = 0; k < 5; k++) begin
      codop = 4'd1; operando1 = 16'($urandom); operando2 = 16'($urandom); valido_in = 1'b1;
      @(posedge clk); #1;
      chk("bp_hold_res", resultado, r0);
      chk("bp_hold_flags", flags, f0);
      chk("bp_hold_valid", valido_out, 1);
      chk("bp_hold_busy", pronto_in, 0);
    end
    pronto_out = 1'b1;
    @(posedge clk); #1;
    pronto_out = 1'b0;
    chk("bp_release_valid", valido_out, 0);
    chk("bp_release_ready", pronto_in, 1);
    valido_in = 1'b0;
    @(posedge clk); #1;
    chk("bp_no_accept", valido_out, 0);
    $display("backpressure: res=%h flags=%b", r0, f0);

    // Multiply with junk commands during the iterations
    codop = 4'd8; operando1 = 16'h00FF; operando2 = 16'h0101; valido_in = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (!valido_out && lat < 100) begin
      chk("mul_busy", pronto_in, 0);
      codop = 4'd0; operando1 = 16'($urandom); operando2 = 16'($urandom); valido_in = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    valido_in = 1'b0;
    chk("mul_junk_lat", lat, 17);
    chk("mul_junk_res", resultado, 16'hFFFF);
    chk("mul_junk_flags", flags, 5'b01000);
    $display("mul junk: res=%h flags=%b lat=%0d", resultado, flags, lat);
    pronto_out = 1'b1;
    @(posedge clk); #1;
    pronto_out = 1'b0;

    // Reset mid-multiply
    codop = 4'd8; operando1 = 16'h0123; operando2 = 16'h0456; valido_in = 1'b1;
    @(posedge clk); #1;
    valido_in = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    chk("rstmul_res", resultado, 0);
    chk("rstmul_flags", flags, 0);
    chk("rstmul_valid", valido_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (valido_out) seen++;
    end
    chk("rstmul_no_valid", seen, 0);
    do_op(4'd0, 16'd2, 16'd3, r, f, lat);
    chk("rstmul_add_res", r, 16'd5);
    chk("rstmul_add_lat", lat, 1);
    $display("reset mid-mul: then add 2+3 -> res=%h lat=%0d", r, lat);

    // 8-bit instance: FF + 01
    c8 = 4'd0; a8 = 8'hFF; b8 = 8'h01; vi8 = 1'b1;
    @(posedge clk); #1;
    vi8 = 1'b0;
    chk("w8_valid", vo8, 1);
    chk("w8_res", r8, 8'h00);
    chk("w8_flags", f8, 5'b00011);
    po8 = 1'b1;
    @(posedge clk); #1;
    po8 = 1'b0;
    chk("w8_ready", pi8, 1);
    $display("w8 add: res=%h flags=%b", r8, f8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
